// File: rtl/fd_de_pipe.sv
// Front-end pipeline registers (PC, F/D, D/E) for the 5-stage MIPS core, plus a saturating stall counter.
// Latency: F_PC instruction reaches D_Instr after 1 cycle and E_Instr after 2; all outputs are registered.
// Backpressure: Stall freezes PC and F/D and loads a bubble (all zeros) into D/E; redirects wait for a non-stall cycle.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   Stall                  hazard-unit freeze request
//   F_Instr                instruction memory data for F_PC
//   D_Redirect, D_NPC      taken branch / jump from D and its target
//   D_RD1, D_RD2, D_Imm32  D-stage operands and extended immediate
//   D_WriteReg, D_RegWrite D-stage destination register and write enable
//   F_PC                   fetch address
//   D_Instr, D_PC          F/D register contents
//   E_*                    D/E register contents
//   StallCnt               stalled cycles since reset, saturating
module fd_de_pipe #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic [31:0]      F_Instr,
    input  logic             D_Redirect,
    input  logic [31:0]      D_NPC,
    input  logic [31:0]      D_RD1,
    input  logic [31:0]      D_RD2,
    input  logic [31:0]      D_Imm32,
    input  logic [4:0]       D_WriteReg,
    input  logic             D_RegWrite,
    output logic [31:0]      F_PC,
    output logic [31:0]      D_Instr,
    output logic [31:0]      D_PC,
    output logic [31:0]      E_Instr,
    output logic [31:0]      E_PC,
    output logic [31:0]      E_RD1,
    output logic [31:0]      E_RD2,
    output logic [31:0]      E_Imm32,
    output logic [4:0]       E_WriteReg,
    output logic             E_RegWrite,
    output logic [CNT_W-1:0] StallCnt
);

    // Redirect targets are forced word-aligned; PC+4 wraps naturally at 32 bits.
    logic [31:0] pc_next;
    always_comb begin
        pc_next = F_PC + 32'd4;
        if (D_Redirect)
            pc_next = {D_NPC[31:2], 2'b00};
    end

    // PC and F/D: held on stall. The delay-slot instruction already in F is
    // never flushed, so a redirect only changes what is fetched next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_PC    <= PC_RESET;
            D_Instr <= 32'd0;
            D_PC    <= 32'd0;
        end else if (!Stall) begin
            F_PC    <= pc_next;
            D_Instr <= F_Instr;
            D_PC    <= F_PC;
        end
    end

    // D/E: a stall inserts an all-zero bubble (sll $0,$0,0 with no write).
    // Writes targeting $0 are suppressed here so E never carries one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            E_Instr    <= 32'd0;
            E_PC       <= 32'd0;
            E_RD1      <= 32'd0;
            E_RD2      <= 32'd0;
            E_Imm32    <= 32'd0;
            E_WriteReg <= 5'd0;
            E_RegWrite <= 1'b0;
        end else if (Stall) begin
            E_Instr    <= 32'd0;
            E_PC       <= 32'd0;
            E_RD1      <= 32'd0;
            E_RD2      <= 32'd0;
            E_Imm32    <= 32'd0;
            E_WriteReg <= 5'd0;
            E_RegWrite <= 1'b0;
        end else begin
            E_Instr    <= D_Instr;
            E_PC       <= D_PC;
            E_RD1      <= D_RD1;
            E_RD2      <= D_RD2;
            E_Imm32    <= D_Imm32;
            E_WriteReg <= D_WriteReg;
            E_RegWrite <= D_RegWrite && (D_WriteReg != 5'd0);
        end
    end

    // Stall-cycle counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            StallCnt <= '0;
        else if (Stall && (StallCnt != {CNT_W{1'b1}}))
            StallCnt <= StallCnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_fd_de_pipe.sv
// Self-checking bench for fd_de_pipe: directed front-end scenarios plus random traffic against a scoreboard.
// Latency: expected state is queued before each clock edge and compared 1 time unit after it.
// Backpressure: stall cycles are exercised both directed and randomly; counter width is reduced to 4 bits.
module tb_fd_de_pipe;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             Stall;
    logic [31:0]      F_Instr;
    logic             D_Redirect;
    logic [31:0]      D_NPC;
    logic [31:0]      D_RD1;
    logic [31:0]      D_RD2;
    logic [31:0]      D_Imm32;
    logic [4:0]       D_WriteReg;
    logic             D_RegWrite;
    logic [31:0]      F_PC;
    logic [31:0]      D_Instr;
    logic [31:0]      D_PC;
    logic [31:0]      E_Instr;
    logic [31:0]      E_PC;
    logic [31:0]      E_RD1;
    logic [31:0]      E_RD2;
    logic [31:0]      E_Imm32;
    logic [4:0]       E_WriteReg;
    logic             E_RegWrite;
    logic [CNT_W-1:0] StallCnt;

    fd_de_pipe #(.PC_RESET(32'h0000_3000), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .F_Instr(F_Instr),
        .D_Redirect(D_Redirect), .D_NPC(D_NPC), .D_RD1(D_RD1), .D_RD2(D_RD2),
        .D_Imm32(D_Imm32), .D_WriteReg(D_WriteReg), .D_RegWrite(D_RegWrite),
        .F_PC(F_PC), .D_Instr(D_Instr), .D_PC(D_PC), .E_Instr(E_Instr),
        .E_PC(E_PC), .E_RD1(E_RD1), .E_RD2(E_RD2), .E_Imm32(E_Imm32),
        .E_WriteReg(E_WriteReg), .E_RegWrite(E_RegWrite), .StallCnt(StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      d_instr;
        logic [31:0]      d_pc;
        logic [31:0]      e_instr;
        logic [31:0]      e_pc;
        logic [31:0]      e_rd1;
        logic [31:0]      e_rd2;
        logic [31:0]      e_imm;
        logic [4:0]       e_wr;
        logic             e_rw;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    // Instruction memory image; never returns 0 so bubbles are distinguishable.
    function automatic logic [31:0] imem(input logic [31:0] pc);
        case (pc)
            32'h0000_3000: imem = 32'h3408_0001;
            32'h0000_3004: imem = 32'h0109_5020;
            default:       imem = {pc[15:0], 16'hA5A5};
        endcase
    endfunction

    function automatic exp_t reset_state();
        exp_t r;
        r     = '0;
        r.pc  = 32'h0000_3000;
        return r;
    endfunction

    // Expected register contents after the next rising edge.
    function automatic exp_t model_next();
        exp_t n;
        n = m;
        if (Stall) begin
            n.e_instr = 32'd0; n.e_pc = 32'd0; n.e_rd1 = 32'd0;
            n.e_rd2 = 32'd0; n.e_imm = 32'd0; n.e_wr = 5'd0; n.e_rw = 1'b0;
            if (m.cnt != 4'hF) n.cnt = m.cnt + 4'd1;
        end else begin
            n.pc      = D_Redirect ? (D_NPC & 32'hFFFF_FFFC) : m.pc + 32'd4;
            n.d_instr = imem(m.pc);
            n.d_pc    = m.pc;
            n.e_instr = m.d_instr;
            n.e_pc    = m.d_pc;
            n.e_rd1   = D_RD1;
            n.e_rd2   = D_RD2;
            n.e_imm   = D_Imm32;
            n.e_wr    = D_WriteReg;
            n.e_rw    = D_RegWrite & (D_WriteReg != 5'd0);
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic rand_d();
        D_RD1      = $urandom;
        D_RD2      = $urandom;
        D_Imm32    = $urandom;
        D_WriteReg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        D_RegWrite = 1'($urandom);
    endtask

    // One clock: queue the expectation, take the edge, compare every output.
    task automatic step();
        exp_t e;
        rand_d();
        sb.push_back(model_next());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("F_PC", F_PC, e.pc);
            chk("D_Instr", D_Instr, e.d_instr);
            chk("D_PC", D_PC, e.d_pc);
            chk("E_Instr", E_Instr, e.e_instr);
            chk("E_PC", E_PC, e.e_pc);
            chk("E_RD1", E_RD1, e.e_rd1);
            chk("E_RD2", E_RD2, e.e_rd2);
            chk("E_Imm32", E_Imm32, e.e_imm);
            chk("E_WriteReg", 32'(E_WriteReg), 32'(e.e_wr));
            chk("E_RegWrite", 32'(E_RegWrite), 32'(e.e_rw));
            chk("StallCnt", 32'(StallCnt), 32'(e.cnt));
            m = e;
        end
        F_Instr = imem(F_PC);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_F_PC"}, F_PC, 32'h0000_3000);
        chk({tag, "_D_Instr"}, D_Instr, 32'd0);
        chk({tag, "_D_PC"}, D_PC, 32'd0);
        chk({tag, "_E_Instr"}, E_Instr, 32'd0);
        chk({tag, "_E_PC"}, E_PC, 32'd0);
        chk({tag, "_E_RD1"}, E_RD1, 32'd0);
        chk({tag, "_E_WriteReg"}, 32'(E_WriteReg), 32'd0);
        chk({tag, "_E_RegWrite"}, 32'(E_RegWrite), 32'd0);
        chk({tag, "_StallCnt"}, 32'(StallCnt), 32'd0);
    endtask

    initial begin
        logic [31:0] hold_pc;
        int          bubbles;

        // Reset held with random inputs toggling underneath.
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Stall = 1'($urandom); D_Redirect = 1'($urandom); D_NPC = $urandom;
            F_Instr = $urandom; rand_d();
            @(posedge clk);
        end
        #1;
        chk_reset_values("rst");

        reset = 1'b0; Stall = 1'b0; D_Redirect = 1'b0; D_NPC = 32'd0;
        F_Instr = imem(F_PC);
        m = reset_state();
        chk("fetch0", F_PC, 32'h0000_3000);

        // Straight-line flow.
        step();
        chk("fetch1", F_PC, 32'h0000_3004);
        chk("sl_D_Instr", D_Instr, 32'h3408_0001);
        chk("sl_D_PC", D_PC, 32'h0000_3000);
        step();
        chk("fetch2", F_PC, 32'h0000_3008);
        chk("sl_E_Instr", E_Instr, 32'h3408_0001);
        chk("sl_D_Instr2", D_Instr, 32'h0109_5020);

        // Single load-use stall.
        Stall = 1'b1;
        step();
        chk("lu_F_PC", F_PC, 32'h0000_3008);
        chk("lu_D_Instr", D_Instr, 32'h0109_5020);
        chk("lu_E_Instr", E_Instr, 32'd0);
        chk("lu_E_RegWrite", 32'(E_RegWrite), 32'd0);
        chk("lu_StallCnt", 32'(StallCnt), 32'd1);
        Stall = 1'b0;
        step();
        chk("lu_E_after", E_Instr, 32'h0109_5020);
        chk("lu_F_PC_after", F_PC, 32'h0000_300C);

        // Redirect with unaligned target; delay slot survives.
        D_Redirect = 1'b1; D_NPC = 32'h0000_3043;
        step();
        chk("rd_F_PC", F_PC, 32'h0000_3040);
        chk("rd_D_PC", D_PC, 32'h0000_300C);
        D_Redirect = 1'b0;

        // Stall and redirect together for two cycles, then release.
        hold_pc = F_PC;
        bubbles = 0;
        Stall = 1'b1; D_Redirect = 1'b1; D_NPC = 32'h0000_3080;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("sr_frozen", F_PC, hold_pc);
            if (E_Instr == 32'd0) bubbles++;
        end
        Stall = 1'b0;
        step();
        chk("sr_target", F_PC, 32'h0000_3080);
        if (E_Instr == 32'd0) bubbles++;
        chk("sr_bubbles", 32'(bubbles), 32'd2);
        D_Redirect = 1'b0;

        // PC+4 wraps at the top of the address space.
        D_Redirect = 1'b1; D_NPC = 32'hFFFF_FFFF;
        step();
        chk("wrap_top", F_PC, 32'hFFFF_FFFC);
        D_Redirect = 1'b0;
        step();
        chk("wrap_zero", F_PC, 32'h0000_0000);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            Stall      = ($urandom_range(0, 3) == 0);
            D_Redirect = ($urandom_range(0, 4) == 0);
            D_NPC      = $urandom;
            step();
        end

        // Counter saturation.
        Stall = 1'b1; D_Redirect = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_StallCnt", 32'(StallCnt), 32'd15);

        // Asynchronous reset mid-run: outputs clear before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("arst");
        @(negedge clk);
        reset = 1'b0; Stall = 1'b0; D_Redirect = 1'b0;
        F_Instr = imem(F_PC);
        m = reset_state();
        sb.delete();
        step();
        chk("arst_fetch1", F_PC, 32'h0000_3004);
        chk("arst_D_PC", D_PC, 32'h0000_3000);
        step();
        chk("arst_fetch2", F_PC, 32'h0000_3008);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
